countdown_timer_ctrl: RTL and testbench
=======================================

COUNTDOWN_TIMER_CTRL -- requirements
Module: countdown_timer_ctrl

Interface
REQ-001 Parameter: TICK_DIV, default 50000000, clk cycles per one-second tick (benches use 4).
REQ-002 Port: clk  input  1  system clock; all state on posedge.
REQ-003 Port: clr  input  1  reset, asynchronous, active-high.
REQ-004 Port: start  input  1  one-cycle pulse; begin or resume countdown.
REQ-005 Port: pause  input  1  one-cycle pulse; freeze countdown.
REQ-006 Port: load  input  1  one-cycle pulse; load preset and return to IDLE.
REQ-007 Port: preset  input  16  BCD mm:ss preset, [15:12] m1, [11:8] m0, [7:4] s1, [3:0] s0.
REQ-008 Port: digits  output  16  current BCD mm:ss value, same field order as preset.
REQ-009 Port: state  output  2  FSM state: IDLE=0, RUN=1, PAUSE=2, DONE=3.
REQ-010 Port: tick  output  1  one-cycle pulse on each one-second decrement.
REQ-011 Port: done  output  1  level, high exactly while state is DONE.

Function
REQ-012 The prescaler SHALL count 0..TICK_DIV-1 only in RUN, assert tick for the one cycle in which it holds TICK_DIV-1, and wrap to 0 on that cycle.
REQ-013 The prescaler SHALL hold its value in PAUSE, so resume continues the partial second.
REQ-014 The prescaler SHALL clear to 0 on load and on entry to DONE.
REQ-015 On tick, digits SHALL decrement by one second with borrow: s0 9..0, s1 5..0, m0 9..0, m1 9..0.
REQ-016 Example borrow: 10:00 -> 09:59.
REQ-017 Decrement SHALL never go below 00:00.
REQ-018 A tick that makes digits 00:00 SHALL move the FSM to DONE in the same edge, with digits = 0000.
REQ-019 IDLE transitions: start with digits != 0000 -> RUN; start with digits == 0000 -> stay IDLE; pause ignored.
REQ-020 RUN transitions: pause -> PAUSE; terminal tick -> DONE.
REQ-021 PAUSE transitions: start -> RUN; pause ignored.
REQ-022 DONE: start and pause SHALL be ignored.
REQ-023 load SHALL be honoured in every state: digits <= preset, FSM -> IDLE.
REQ-024 A preset with any field out of range (s1 > 5, or any digit > 9) SHALL leave digits unchanged, with FSM still -> IDLE.
REQ-025 Same-cycle priority: load > start > pause.
REQ-026 In RUN, tick and pause in the same cycle: the decrement is applied and the next state is PAUSE (DONE if the tick was terminal).
REQ-027 Latency: every input pulse SHALL take effect at the next posedge; all outputs SHALL be registered.

Reset
REQ-028 While clr=1, independent of clk: state=IDLE, digits=0000, prescaler=0, tick=0, done=0.
REQ-029 clr asserted mid-RUN SHALL discard the partial second.
REQ-030 After clr deasserts, the first start with digits 0000 SHALL stay in IDLE.

Structure
REQ-031 State encodings, the BCD field limits (9, 5) and the digits field offsets SHALL live in the shared package timer_pkg.
REQ-032 One sub-module, bcd_digit_dn, SHALL be instantiated four times.
REQ-033 bcd_digit_dn: parameterised max value, with load, enable and borrow-out; borrow is asserted when the digit is 0 and enable is high.
REQ-034 The borrow chain SHALL be combinational across the four instances within one cycle.

Verification (TICK_DIV=4)
REQ-035 Basic countdown: load 0003, start -> tick every 4 cycles; digits 0002, 0001, 0000; done=1 and state=3 after 12 cycles.
REQ-036 Borrow: load 1000, start, 1 tick -> digits 0959; later from 0100, 1 tick -> 0059.
REQ-037 Pause/resume: start, pause at prescaler=2, hold 10 cycles -> digits unchanged; start -> next tick 2 cycles later.
REQ-038 Priority: load=start=pause=1 in RUN with preset 0530 -> state IDLE, digits 0530; invalid preset 0070 -> digits unchanged.
REQ-039 Edge starts: start at 0000 -> state stays 0; start in DONE -> ignored, done stays 1.
REQ-040 Async reset: clr pulsed between clk edges mid-RUN -> immediate IDLE, digits 0000, tick 0.

Source files
------------

// File: rtl/timer_pkg.sv
// timer_pkg: shared FSM encoding, BCD field limits/offsets and preset validity check for the mm:ss countdown timer
package timer_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3} state_t;
  localparam logic [3:0] DIGIT_MAX = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam int FIELD_LSB [4] = '{0, 4, 8, 12};
  localparam logic [3:0] FIELD_MAX [4] = '{DIGIT_MAX, SEC_TENS_MAX, DIGIT_MAX, DIGIT_MAX};
  function automatic logic bcd_valid(input logic [15:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) if (v[FIELD_LSB[i] +: 4] > FIELD_MAX[i]) ok = 1'b0;
    return ok;
  endfunction
endpackage

// File: rtl/bcd_digit_dn.sv
// bcd_digit_dn: one BCD down-counting digit (clk, clr async reset, ld/ld_val load, en decrement, val digit, borrow = en at 0)
module bcd_digit_dn #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       ld,
  input  logic [3:0] ld_val,
  input  logic       en,
  output logic [3:0] val,
  output logic       borrow
);
  assign borrow = en && val == 4'd0;
  always_ff @(posedge clk or posedge clr)
    if (clr) val <= '0;
    else if (ld) val <= ld_val;
    else if (en) val <= borrow ? MAX : val - 4'd1;
endmodule

// File: rtl/countdown_timer_ctrl.sv
// countdown_timer_ctrl: mm:ss BCD countdown (clk, clr async reset, start/pause/load pulses, preset in; digits, state, tick, done out)
module countdown_timer_ctrl
  import timer_pkg::*;
#(
  parameter int TICK_DIV = 50000000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic        pause,
  input  logic        load,
  input  logic [15:0] preset,
  output logic [15:0] digits,
  output logic [1:0]  state,
  output logic        tick,
  output logic        done
);
  localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
  state_t cur, nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [4:0] b;
  logic dec, ld, term;
  assign dec = tick && !load;
  assign b[0] = dec;
  assign ld = (load && bcd_valid(preset)) || b[4];
  assign term = dec && digits == 16'h0001;
  assign state = cur;
  always_comb begin
    nxt = load ? IDLE :
          term ? DONE :
          start && cur == IDLE && digits != 16'h0000 ? RUN :
          start && cur == PAUSE ? RUN :
          pause && !start && cur == RUN ? PAUSE : cur;
    cnt_nxt = (load || nxt == DONE) ? '0 :
              cur == RUN ? (cnt == LAST ? '0 : cnt + CW'(1)) : cnt;
  end
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      cur  <= IDLE;
      cnt  <= '0;
      tick <= 1'b0;
      done <= 1'b0;
    end else begin
      cur  <= nxt;
      cnt  <= cnt_nxt;
      tick <= nxt == RUN && cnt_nxt == LAST;
      done <= nxt == DONE;
    end
  for (genvar i = 0; i < 4; i++) begin : g_dig
    bcd_digit_dn #(.MAX(FIELD_MAX[i])) u_dig (
      .clk    (clk),
      .clr    (clr),
      .ld     (ld),
      .ld_val (load ? preset[FIELD_LSB[i] +: 4] : digits[FIELD_LSB[i] +: 4]),
      .en     (b[i]),
      .val    (digits[FIELD_LSB[i] +: 4]),
      .borrow (b[i+1])
    );
  end
endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// tb_countdown_timer_ctrl: directed self-checking bench for countdown_timer_ctrl with TICK_DIV=4
module tb_countdown_timer_ctrl;
  logic clk = 1'b0;
  logic clr = 1'b0;
  logic start = 1'b0;
  logic pause = 1'b0;
  logic load = 1'b0;
  logic [15:0] preset = '0;
  logic [15:0] digits;
  logic [1:0] state;
  logic tick, done;
  int n_chk = 0;
  int n_err = 0;
  countdown_timer_ctrl #(.TICK_DIV(4)) dut (
    .clk    (clk),
    .clr    (clr),
    .start  (start),
    .pause  (pause),
    .load   (load),
    .preset (preset),
    .digits (digits),
    .state  (state),
    .tick   (tick),
    .done   (done)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic pulse(input logic s, input logic p, input logic l);
    start = s;
    pause = p;
    load = l;
    cyc(1);
    start = 1'b0;
    pause = 1'b0;
    load = 1'b0;
  endtask
  initial begin
    #1 clr = 1'b1;
    #2;
    check("rst_state", 16'(state), 16'd0);
    check("rst_digits", digits, 16'h0000);
    check("rst_tick", 16'(tick), 16'd0);
    check("rst_done", 16'(done), 16'd0);
    cyc(2);
    clr = 1'b0;
    pulse(1, 0, 0);
    check("start_zero_state", 16'(state), 16'd0);
    preset = 16'h0003;
    pulse(0, 0, 1);
    check("load3_digits", digits, 16'h0003);
    check("load3_state", 16'(state), 16'd0);
    pulse(1, 0, 0);
    check("run_state", 16'(state), 16'd1);
    cyc(3);
    check("tick1_high", 16'(tick), 16'd1);
    check("tick1_digits", digits, 16'h0003);
    cyc(1);
    check("dec1_digits", digits, 16'h0002);
    check("dec1_tick", 16'(tick), 16'd0);
    cyc(4);
    check("dec2_digits", digits, 16'h0001);
    check("dec2_done", 16'(done), 16'd0);
    cyc(4);
    check("term_digits", digits, 16'h0000);
    check("term_state", 16'(state), 16'd3);
    check("term_done", 16'(done), 16'd1);
    pulse(1, 0, 0);
    check("done_start_state", 16'(state), 16'd3);
    check("done_start_done", 16'(done), 16'd1);
    pulse(0, 1, 0);
    check("done_pause_state", 16'(state), 16'd3);
    preset = 16'h0070;
    pulse(0, 0, 1);
    check("bad_preset_state", 16'(state), 16'd0);
    check("bad_preset_digits", digits, 16'h0000);
    check("bad_preset_done", 16'(done), 16'd0);
    preset = 16'h1000;
    pulse(0, 0, 1);
    pulse(1, 0, 0);
    cyc(4);
    check("borrow_1000", digits, 16'h0959);
    preset = 16'h0100;
    pulse(0, 0, 1);
    pulse(1, 0, 0);
    cyc(4);
    check("borrow_0100", digits, 16'h0059);
    preset = 16'h0005;
    pulse(0, 0, 1);
    pulse(1, 0, 0);
    cyc(1);
    pulse(0, 1, 0);
    check("pause_state", 16'(state), 16'd2);
    cyc(10);
    check("pause_hold_digits", digits, 16'h0005);
    check("pause_hold_state", 16'(state), 16'd2);
    check("pause_hold_tick", 16'(tick), 16'd0);
    pulse(0, 1, 0);
    check("pause_in_pause", 16'(state), 16'd2);
    pulse(1, 0, 0);
    check("resume_state", 16'(state), 16'd1);
    check("resume_tick0", 16'(tick), 16'd0);
    cyc(1);
    check("resume_tick1", 16'(tick), 16'd1);
    check("resume_digits_pre", digits, 16'h0005);
    cyc(1);
    check("resume_dec", digits, 16'h0004);
    cyc(3);
    check("tp_tick", 16'(tick), 16'd1);
    pulse(0, 1, 0);
    check("tp_digits", digits, 16'h0003);
    check("tp_state", 16'(state), 16'd2);
    pulse(1, 0, 0);
    preset = 16'h0530;
    pulse(1, 1, 1);
    check("prio_state", 16'(state), 16'd0);
    check("prio_digits", digits, 16'h0530);
    pulse(1, 0, 0);
    cyc(2);
    #3 clr = 1'b1;
    #1;
    check("async_state", 16'(state), 16'd0);
    check("async_digits", digits, 16'h0000);
    check("async_tick", 16'(tick), 16'd0);
    #1 clr = 1'b0;
    cyc(1);
    pulse(1, 0, 0);
    check("post_clr_start", 16'(state), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
